sonar_ping_sequencer: RTL and testbench
=======================================

// Module: sonar_ping_sequencer
// PURPOSE
//  Measurement sequencer for the sonar datapath: paces the PCM chain, fires the transmit burst,
//  blanks crosstalk, clears the compare latch/timer, and captures the time of flight (TOF) on echo.
//  Sits beside the sonar datapath on the 16-bit WB slave bus. ce_pcm_o/mclear_o drive the datapath;
//  cmp_i is its latched compare output.
// PARAMETERS
//  BUS_WIDTH  16  register/data width (TOF, counters, bus)
// PORTS
//  wb_clk_i     in   1   single system clock
//  wb_rst_n_i   in   1   reset, asynchronous, active-low
//  wb_valid_i   in   1   bus cycle valid
//  wbs_adr_i    in   4   register address
//  wbs_dat_i    in   16  write data
//  wbs_strb_i   in   1   write strobe (1=write, 0=read)
//  wbs_ack_o    out  1   ack, 1 clk after each valid cycle
//  wbs_dat_o    out  16  registered read data
//  cmp_i        in   1   latched compare output from the datapath
//  ce_pcm_o     out  1   PCM pace strobe (1-clk pulse)
//  mclear_o     out  1   master clear to the datapath latch and timer (1-clk pulse)
//  tx_o         out  1   transducer drive
//  irq_o        out  1   ping-done interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all registers 0; state IDLE; every output 0.
//  Regs: 0 CTRL[0]=en,[1]=start(self-clearing),[2]=continuous; 1 PCM_DIV; 2 TX_HALF; 3 TX_CYCLES;
//   4 BLANK; 5 WINDOW; 6 INTERVAL (4-6 in PCM ticks); 7 STATUS RO {[6:4]=state,[2]=timeout,[1]=hit,
//   [0]=done}, writing 1 to bit0 clears done (W1C); 8 TOF RO; 9 PING_CNT RO; other addresses read 0.
//  Bus: read data and ack are registered 1 clk after valid. Write takes effect the same edge.
//  ce_pcm_o: when en=1, divider pulses once every PCM_DIV+1 clks (0 -> every clk). When en=0, held 0.
//   The divider restarts at 0 when en rises.
//  FSM: IDLE->CLEAR on start&en (start ignored outside IDLE; start is always self-cleared).
//   CLEAR: mclear_o=1 for 1 clk; clears hit/timeout; ->TX (->BLANK if TX_CYCLES=0).
//   TX: tx_o starts 1 and toggles every TX_HALF+1 clks; leaves after 2*TX_CYCLES half-periods,
//    tx_o=0 on exit; ->BLANK.
//   BLANK: cmp_i ignored; count BLANK ticks (0 -> pass through); on exit mclear_o=1 for 1 clk; ->LISTEN.
//   LISTEN: tof counter +1 per ce_pcm_o. If cmp_i=1, TOF<=tof, hit=1, ->DONE.
//    If tof reaches WINDOW without cmp_i, TOF<=16'hFFFF, timeout=1, ->DONE.
//    If cmp_i and the last window tick coincide, it counts as a hit.
//   DONE: done=1, PING_CNT+1 (wraps FFFF->0) on entry; wait INTERVAL ticks;
//    -> CLEAR if continuous else IDLE.
//  tof saturates at FFFF and never wraps. TOF holds its value until the next capture.
//  en<-0 in any state: -> IDLE next clk; tx_o=0; mclear_o=0; TOF/STATUS/PING_CNT unchanged.
//  Async reset mid-ping: outputs 0 immediately; no pulse completes.
//  Write to a config reg mid-ping: new value used by the counter on its next compare.
// CONFIGURATION
//  SONAR_SEQ_IRQ_EN defined:
//   - irq_o is set on DONE entry and held until done is cleared via the STATUS W1C.
//   - CTRL[3]=irq mask; irq_o = done & CTRL[3].
//  Not defined: irq_o tied 0; CTRL[3] reads 0.
// TESTING
//  Reset, then read all regs -> all 0; ack 1 clk after valid; ce_pcm_o, tx_o, mclear_o = 0.
//  en=1, PCM_DIV=3 -> ce_pcm_o pulses every 4 clks.
//  TX_HALF=2, TX_CYCLES=2, start -> mclear 1 clk, then tx_o high 3/low 3 twice, then 0.
//  BLANK=5, WINDOW=100, cmp_i=1 during BLANK, then cmp_i=1 at LISTEN tick 40
//   -> blank-end mclear; TOF=40; hit=1; done=1; PING_CNT=1.
//  No cmp_i, WINDOW=10 -> TOF=FFFF, timeout=1; continuous=1, INTERVAL=4 -> CLEAR re-entered 4 ticks later.
//  en<-0 mid-TX -> IDLE next clk, tx_o=0, TOF unchanged.
//  With IRQ_EN and mask=1: irq_o rises on done; W1C STATUS[0] -> irq_o=0.

Source files
------------

// File: rtl/sonar_ping_sequencer.sv
// rtl/sonar_ping_sequencer.sv - sonar ping sequencer: PCM pacing, TX burst, blanking, TOF capture
// Optional feature macro: SONAR_SEQ_IRQ_EN (masked ping-done interrupt on irq_o, mask in CTRL[3]).
module sonar_ping_sequencer #(
   parameter int BUS_WIDTH = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n_i,
   input  logic                 wb_valid_i,
   input  logic [3:0]           wbs_adr_i,
   input  logic [BUS_WIDTH-1:0] wbs_dat_i,
   input  logic                 wbs_strb_i,
   output logic                 wbs_ack_o,
   output logic [BUS_WIDTH-1:0] wbs_dat_o,
   input  logic                 cmp_i,
   output logic                 ce_pcm_o,
   output logic                 mclear_o,
   output logic                 tx_o,
   output logic                 irq_o
);
   localparam logic [BUS_WIDTH-1:0] SAT = '1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_TX     = 3'd2,
      S_BLANK  = 3'd3,
      S_LISTEN = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   logic                 r_en, r_start, r_cont;
   logic [BUS_WIDTH-1:0] r_pcm_div, r_tx_half, r_tx_cycles, r_blank, r_window, r_interval;
   logic                 r_ack;
   logic [BUS_WIDTH-1:0] r_dat;
   logic [BUS_WIDTH-1:0] r_div;
   logic                 r_ce;
   state_t               r_state;
   logic                 r_mclear, r_tx, r_done, r_hit, r_timeout;
   logic [BUS_WIDTH-1:0] r_cnt, r_tof, r_tof_cap, r_ping_cnt;
   logic [BUS_WIDTH:0]   r_half;

   logic                 w_wr, w_w1c, w_irq_mask;
   logic [BUS_WIDTH-1:0] w_rd_data, w_tof_inc, w_tof_next;
   logic [BUS_WIDTH:0]   w_half_next;

   assign w_wr        = wb_valid_i & wbs_strb_i;
   assign w_w1c       = w_wr && (wbs_adr_i == 4'd7) && wbs_dat_i[0];
   assign w_tof_inc   = (r_tof == SAT) ? r_tof : r_tof + 1'b1;
   assign w_tof_next  = r_ce ? w_tof_inc : r_tof;
   assign w_half_next = r_half + 1'b1;

`ifdef SONAR_SEQ_IRQ_EN
   logic r_irq_mask;
   assign w_irq_mask = r_irq_mask;
   assign irq_o      = r_done & r_irq_mask;
`else
   assign w_irq_mask = 1'b0;
   assign irq_o      = 1'b0;
`endif

   always_comb begin
      w_rd_data = '0;
      case (wbs_adr_i)
         4'd0: w_rd_data = {{(BUS_WIDTH-4){1'b0}}, w_irq_mask, r_cont, 1'b0, r_en};
         4'd1: w_rd_data = r_pcm_div;
         4'd2: w_rd_data = r_tx_half;
         4'd3: w_rd_data = r_tx_cycles;
         4'd4: w_rd_data = r_blank;
         4'd5: w_rd_data = r_window;
         4'd6: w_rd_data = r_interval;
         4'd7: w_rd_data = {{(BUS_WIDTH-7){1'b0}}, r_state, 1'b0, r_timeout, r_hit, r_done};
         4'd8: w_rd_data = r_tof_cap;
         4'd9: w_rd_data = r_ping_cnt;
         default: w_rd_data = '0;
      endcase
   end

   // Register file; start is a one-clock pulse regardless of what the FSM does with it.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_en        <= 1'b0;
         r_start     <= 1'b0;
         r_cont      <= 1'b0;
         r_pcm_div   <= '0;
         r_tx_half   <= '0;
         r_tx_cycles <= '0;
         r_blank     <= '0;
         r_window    <= '0;
         r_interval  <= '0;
         r_ack       <= 1'b0;
         r_dat       <= '0;
`ifdef SONAR_SEQ_IRQ_EN
         r_irq_mask  <= 1'b0;
`endif
      end else begin
         r_start <= 1'b0;
         r_ack   <= wb_valid_i;
         r_dat   <= (wb_valid_i && !wbs_strb_i) ? w_rd_data : '0;
         if (w_wr) begin
            case (wbs_adr_i)
               4'd0: begin
                  r_en    <= wbs_dat_i[0];
                  r_start <= wbs_dat_i[1];
                  r_cont  <= wbs_dat_i[2];
`ifdef SONAR_SEQ_IRQ_EN
                  r_irq_mask <= wbs_dat_i[3];
`endif
               end
               4'd1: r_pcm_div   <= wbs_dat_i;
               4'd2: r_tx_half   <= wbs_dat_i;
               4'd3: r_tx_cycles <= wbs_dat_i;
               4'd4: r_blank     <= wbs_dat_i;
               4'd5: r_window    <= wbs_dat_i;
               4'd6: r_interval  <= wbs_dat_i;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_div <= '0;
         r_ce  <= 1'b0;
      end else if (!r_en) begin
         r_div <= '0;
         r_ce  <= 1'b0;
      end else if (r_div >= r_pcm_div) begin
         r_div <= '0;
         r_ce  <= 1'b1;
      end else begin
         r_div <= r_div + 1'b1;
         r_ce  <= 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_state    <= S_IDLE;
         r_mclear   <= 1'b0;
         r_tx       <= 1'b0;
         r_done     <= 1'b0;
         r_hit      <= 1'b0;
         r_timeout  <= 1'b0;
         r_cnt      <= '0;
         r_half     <= '0;
         r_tof      <= '0;
         r_tof_cap  <= '0;
         r_ping_cnt <= '0;
      end else begin
         r_mclear <= 1'b0;
         if (w_w1c) r_done <= 1'b0;
         if (!r_en) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: if (r_start) begin
                  r_state  <= S_CLEAR;
                  r_mclear <= 1'b1;
               end
               S_CLEAR: begin
                  r_hit     <= 1'b0;
                  r_timeout <= 1'b0;
                  r_cnt     <= '0;
                  r_half    <= '0;
                  if (r_tx_cycles == '0) r_state <= S_BLANK;
                  else begin
                     r_state <= S_TX;
                     r_tx    <= 1'b1;
                  end
               end
               S_TX: if (r_cnt >= r_tx_half) begin
                  r_cnt  <= '0;
                  r_half <= w_half_next;
                  r_tx   <= ~r_tx;
                  if (w_half_next >= {r_tx_cycles, 1'b0}) begin
                     r_tx    <= 1'b0;
                     r_state <= S_BLANK;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
               S_BLANK: if (r_cnt >= r_blank) begin
                  r_state  <= S_LISTEN;
                  r_mclear <= 1'b1;
                  r_tof    <= '0;
               end else if (r_ce) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               S_LISTEN: begin
                  r_tof <= w_tof_next;
                  // cmp_i is stale while the latch is still being cleared
                  if ((cmp_i && !r_mclear) || (w_tof_next >= r_window)) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_ping_cnt <= r_ping_cnt + 1'b1;
                     r_cnt      <= '0;
                     if (cmp_i && !r_mclear) begin
                        r_tof_cap <= w_tof_next;
                        r_hit     <= 1'b1;
                     end else begin
                        r_tof_cap <= SAT;
                        r_timeout <= 1'b1;
                     end
                  end
               end
               S_DONE: if (r_cnt >= r_interval) begin
                  if (r_cont) begin
                     r_state  <= S_CLEAR;
                     r_mclear <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else if (r_ce) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign ce_pcm_o  = r_ce;
   assign mclear_o  = r_mclear;
   assign tx_o      = r_tx;
endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// tb/tb_sonar_ping_sequencer.sv - directed self-checking bench for sonar_ping_sequencer
module tb_sonar_ping_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        strb = 1'b0;
   logic        cmp = 1'b0;
   logic [3:0]  adr = '0;
   logic [15:0] wdat = '0;
   logic        ack, ce, mclr, tx, irq;
   logic [15:0] rdat;

   int          n_checks = 0;
   int          n_errors = 0;
   int          ce_total = 0;
   logic [15:0] rd;
   logic [15:0] obs_tx, obs_mclr;
   int          n, t, s2;

   sonar_ping_sequencer #(.BUS_WIDTH(16)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wb_valid_i (valid),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (wdat),
      .wbs_strb_i (strb),
      .wbs_ack_o  (ack),
      .wbs_dat_o  (rdat),
      .cmp_i      (cmp),
      .ce_pcm_o   (ce),
      .mclear_o   (mclr),
      .tx_o       (tx),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ce) ce_total <= ce_total + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      valid = 1'b1; strb = 1'b1; adr = a; wdat = d;
      @(negedge clk);
      valid = 1'b0; strb = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
      @(negedge clk);
      valid = 1'b1; strb = 1'b0; adr = a;
      @(negedge clk);
      valid = 1'b0;
      check("ack", ack, 1);
      d = rdat;
   endtask

   task automatic wait_mclear(input string tag);
      int k;
      k = 0;
      while (!mclr && k < 500) begin
         @(negedge clk);
         k++;
      end
      check(tag, mclr, 1);
   endtask

   task automatic wait_tx(input string tag);
      int k;
      k = 0;
      while (!tx && k < 100) begin
         @(negedge clk);
         k++;
      end
      check(tag, tx, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ce", ce, 0);
      check("rst_mclear", mclr, 0);
      check("rst_tx", tx, 0);
      check("rst_irq", irq, 0);
      check("rst_ack", ack, 0);
      rst_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         bus_read(a[3:0], rd);
         check($sformatf("rst_reg%0d", a), rd, 0);
      end

      // PCM pacing
      bus_write(4'd1, 16'd3);
      bus_write(4'd0, 16'h0001);
      n = 0;
      while (!ce && n < 20) begin @(negedge clk); n++; end
      check("ce_seen", ce, 1);
      n = 0;
      do begin @(negedge clk); n++; end while (!ce && n < 20);
      check("ce_period", n, 4);
      bus_read(4'd1, rd);
      check("pcm_div_rb", rd, 16'd3);

      // TX burst then hit at tick 40
      bus_write(4'd2, 16'd2);
      bus_write(4'd3, 16'd2);
      bus_write(4'd4, 16'd5);
      bus_write(4'd5, 16'd100);
      bus_write(4'd0, 16'h0003);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         obs_tx[i]   = tx;
         obs_mclr[i] = mclr;
      end
      check("tx_wave", obs_tx, 16'h071C);
      check("clear_mclear_wave", obs_mclr, 16'h0002);
      cmp = 1'b1;
      wait_mclear("blank_end_mclear");
      cmp = 1'b0;
      t = ce ? 1 : 0;
      n = 0;
      while (t < 40 && n < 400) begin
         @(negedge clk);
         n++;
         if (ce) t++;
      end
      cmp = 1'b1;
      @(negedge clk);
      cmp = 1'b0;
      repeat (3) @(negedge clk);
      bus_read(4'd7, rd);
      check("hit_status", rd, 16'h0003);
      bus_read(4'd8, rd);
      check("hit_tof", rd, 16'd40);
      bus_read(4'd9, rd);
      check("ping_cnt1", rd, 16'd1);

      // Timeout with continuous re-arm
      bus_write(4'd7, 16'h0001);
      bus_write(4'd3, 16'd0);
      bus_write(4'd4, 16'd0);
      bus_write(4'd5, 16'd10);
      bus_write(4'd6, 16'd4);
      bus_write(4'd0, 16'h0007);
      wait_mclear("cont_clear_mclear");
      @(negedge clk);
      wait_mclear("cont_listen_mclear");
      s2 = ce_total;
      n = 0;
      while ((ce_total - s2) < 10 && n < 200) begin @(negedge clk); n++; end
      check("timeout_ticks", ce_total - s2, 10);
      bus_read(4'd7, rd);
      check("timeout_status", rd, 16'h0055);
      bus_read(4'd8, rd);
      check("timeout_tof", rd, 16'hFFFF);
      bus_read(4'd9, rd);
      check("ping_cnt2", rd, 16'd2);
      @(negedge clk);
      wait_mclear("reclear_mclear");
      check("interval_ticks", ce_total - s2, 14);
      bus_write(4'd0, 16'h0000);

      // en dropped mid-TX
      bus_write(4'd7, 16'h0001);
      bus_write(4'd3, 16'd4);
      bus_write(4'd0, 16'h0003);
      wait_tx("abort_tx_high");
      bus_write(4'd0, 16'h0000);
      @(negedge clk);
      check("abort_tx", tx, 0);
      check("abort_mclear", mclr, 0);
      check("abort_ce", ce, 0);
      bus_read(4'd7, rd);
      check("abort_status", rd, 16'h0000);
      bus_read(4'd8, rd);
      check("abort_tof", rd, 16'hFFFF);
      bus_read(4'd9, rd);
      check("abort_ping_cnt", rd, 16'd2);

      // Interrupt mask / W1C
      bus_write(4'd3, 16'd0);
      bus_write(4'd5, 16'd2);
      bus_write(4'd0, 16'h000B);
      repeat (40) @(negedge clk);
      bus_read(4'd7, rd);
      check("irq_ping_status", rd, 16'h0005);
      bus_read(4'd9, rd);
      check("ping_cnt3", rd, 16'd3);
      bus_read(4'd0, rd);
`ifdef SONAR_SEQ_IRQ_EN
      check("ctrl_rb", rd, 16'h0009);
      check("irq_set", irq, 1);
      bus_write(4'd7, 16'h0001);
      check("irq_w1c", irq, 0);
`else
      check("ctrl_rb", rd, 16'h0001);
      check("irq_tied", irq, 0);
`endif

      // Async reset in the middle of a burst
      bus_write(4'd3, 16'd4);
      bus_write(4'd0, 16'h0003);
      wait_tx("arst_tx_high");
      #2 rst_n = 1'b0;
      #1;
      check("arst_tx", tx, 0);
      check("arst_mclear", mclr, 0);
      check("arst_ce", ce, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(4'd9, rd);
      check("arst_ping_cnt", rd, 16'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
